risc_spm_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the RISC_SPM core and its SRAM. It accepts a byte stream of checksummed load packets over a valid/ready handshake and writes the payload into SRAM through a write port. It holds the core in reset until a valid terminator packet arrives, then releases it. Benches and boards use it in place of hierarchical memory pokes.

---
 rtl/risc_spm_loader.sv | 128 ++++++++++++
 tb/tb_risc_spm_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_spm_loader.sv
// Boot-time loader: parses checksummed ADDR/LEN/DATA/CHK packets from a byte stream,
// writes the payload to SRAM and releases the RISC_SPM core once a good terminator arrives.
module risc_spm_loader #(
    parameter int unsigned WordSize = 8,
    parameter int unsigned AddrSize = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [WordSize-1:0] in_data_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    output logic [AddrSize-1:0] mem_addr_o,
    output logic [WordSize-1:0] mem_data_o,
    output logic                mem_write_o,
    output logic                cpu_rst_o,
    output logic                load_done_o,
    output logic                load_err_o
);

    typedef enum logic [2:0] {
        StAddr,
        StLen,
        StData,
        StChk,
        StDone,
        StErr
    } state_e;

    state_e              state_q, state_d;
    logic [AddrSize-1:0] ptr_q, ptr_d;
    logic [WordSize-1:0] cnt_q, cnt_d;
    logic [WordSize-1:0] sum_q, sum_d;
    logic                term_q, term_d;
    logic                in_ready_q, in_ready_d;
    logic                mem_write_q, mem_write_d;
    logic [AddrSize-1:0] mem_addr_q, mem_addr_d;
    logic [WordSize-1:0] mem_data_q, mem_data_d;

    logic                accept;
    logic [WordSize-1:0] sum_next;

    assign accept   = in_valid_i && in_ready_q;
    assign sum_next = sum_q + in_data_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StAddr;
            ptr_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            term_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            term_q      <= term_d;
            in_ready_q  <= in_ready_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        term_d      = term_q;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        if (accept) begin
            unique case (state_q)
                StAddr: begin
                    ptr_d   = AddrSize'(in_data_i);
                    sum_d   = in_data_i;
                    state_d = StLen;
                end
                StLen: begin
                    cnt_d   = in_data_i;
                    sum_d   = sum_next;
                    term_d  = (in_data_i == '0);
                    state_d = (in_data_i == '0) ? StChk : StData;
                end
                StData: begin
                    mem_write_d = 1'b1;
                    mem_addr_d  = ptr_q;
                    mem_data_d  = in_data_i;
                    ptr_d       = ptr_q + 1'b1;
                    cnt_d       = cnt_q - 1'b1;
                    sum_d       = sum_next;
                    if (cnt_q == WordSize'(1)) begin
                        state_d = StChk;
                    end
                end
                StChk: begin
                    if (sum_next != '0) begin
                        state_d = StErr;
                    end else if (term_q) begin
                        state_d = StDone;
                    end else begin
                        state_d = StAddr;
                    end
                end
                default: ;
            endcase
        end
        // Ready is registered, so it must drop together with entry into a terminal state.
        in_ready_d = (state_d != StDone) && (state_d != StErr);
    end

    always_comb begin
        in_ready_o  = in_ready_q;
        mem_write_o = mem_write_q;
        mem_addr_o  = mem_addr_q;
        mem_data_o  = mem_data_q;
        cpu_rst_o   = (state_q == StDone);
        load_done_o = (state_q == StDone);
        load_err_o  = (state_q == StErr);
    end

endmodule

// File: tb/tb_risc_spm_loader.sv
// Self-checking bench for risc_spm_loader: directed packets from the test plan plus random
// packet sessions, checked cycle-by-cycle against a packet-level reference model.
module tb_risc_spm_loader;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready_o;
    logic [7:0] mem_addr_o;
    logic [7:0] mem_data_o;
    logic       mem_write_o;
    logic       cpu_rst_o;
    logic       load_done_o;
    logic       load_err_o;

    always #5 clk = ~clk;

    risc_spm_loader #(
        .WordSize(8),
        .AddrSize(8)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_write_o(mem_write_o),
        .cpu_rst_o  (cpu_rst_o),
        .load_done_o(load_done_o),
        .load_err_o (load_err_o)
    );

    int         n_tests = 0;
    int         n_fail = 0;
    int         wr_seen = 0;
    logic [7:0] model_mem[256];
    logic [7:0] dut_mem[256];
    logic [7:0] pk[16];

    // Observed SRAM contents, built only from the write port.
    always @(negedge clk) begin
        if (mem_write_o) begin
            dut_mem[mem_addr_o] = mem_data_o;
            wr_seen++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] good_chk(input logic [7:0] addr, input int len);
        logic [7:0] s;
        s = addr + len[7:0];
        for (int i = 0; i < len; i++) s = s + pk[i];
        return 8'(~s + 8'd1);
    endfunction

    // Called at a negedge; asserts reset at once and returns at a negedge with ready high.
    task automatic do_reset();
        rst_ni   = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_in_ready", in_ready_o, 0);
        check("rst_mem_write", mem_write_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_mem_data", mem_data_o, 0);
        check("rst_cpu_rst", cpu_rst_o, 0);
        check("rst_load_done", load_done_o, 0);
        check("rst_load_err", load_err_o, 0);
        @(negedge clk);
        check("rst_hold_no_write", mem_write_o, 0);
        rst_ni = 1'b1;
        @(negedge clk);
        check("ready_after_reset", in_ready_o, 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit exp_wr, input logic [7:0] exp_addr,
                             input bit throttle);
        int idle;
        int tries;
        idle = throttle ? int'($urandom_range(0, 2)) : 0;
        repeat (idle) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
            check("stall_no_write", mem_write_o, 0);
        end
        in_valid = 1'b1;
        in_data  = b;
        tries    = 0;
        while (!in_ready_o && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        if (!in_ready_o) begin
            check("ready_timeout", in_ready_o, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("write_strobe", mem_write_o, exp_wr);
        if (exp_wr) begin
            check("write_addr", mem_addr_o, exp_addr);
            check("write_data", mem_data_o, b);
            model_mem[exp_addr] = b;
        end
    endtask

    // Sends one packet from pk[] and checks the outcome the packet rules predict.
    task automatic send_packet(input logic [7:0] addr, input int len, input logic [7:0] chk,
                               input bit throttle);
        logic [7:0] a;
        logic [7:0] s;
        bit         good;
        bit         term;
        send_byte(addr, 1'b0, 8'h00, throttle);
        send_byte(len[7:0], 1'b0, 8'h00, throttle);
        s = addr + len[7:0] + chk;
        for (int i = 0; i < len; i++) begin
            a = addr + i[7:0];
            s = s + pk[i];
            send_byte(pk[i], 1'b1, a, throttle);
        end
        send_byte(chk, 1'b0, 8'h00, throttle);
        good = (s == 8'h00);
        term = (len == 0);
        check("load_done", load_done_o, good && term);
        check("load_err", load_err_o, !good);
        check("cpu_rst", cpu_rst_o, good && term);
        check("in_ready_after_chk", in_ready_o, good && !term);
    endtask

    task automatic ignore_bytes(input int n, input bit exp_done, input bit exp_err);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(negedge clk);
            check("ignored_no_write", mem_write_o, 0);
            check("ignored_not_ready", in_ready_o, 0);
        end
        in_valid = 1'b0;
        check("sticky_done", load_done_o, exp_done);
        check("sticky_err", load_err_o, exp_err);
    endtask

    initial begin
        int         npk;
        int         len;
        int         w0;
        logic [7:0] addr;
        bit         thr;

        for (int i = 0; i < 256; i++) begin
            model_mem[i] = 8'h00;
            dut_mem[i]   = 8'h00;
        end
        rst_ni   = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        do_reset();

        // Single packet then terminator.
        pk[0] = 8'h50; pk[1] = 8'h82;
        send_packet(8'h01, 2, 8'h2B, 1'b0);
        send_packet(8'h00, 0, 8'h00, 1'b0);

        // Address wrap, then a terminator proves the FSM is back at ADDR.
        do_reset();
        pk[0] = 8'h11; pk[1] = 8'h22;
        send_packet(8'hFF, 2, 8'hCC, 1'b0);
        send_packet(8'h00, 0, 8'h00, 1'b0);

        // Bad checksum.
        do_reset();
        pk[0] = 8'h06;
        send_packet(8'h80, 1, 8'h00, 1'b0);
        ignore_bytes(4, 1'b0, 1'b1);

        // Throttled repeat of the first test.
        do_reset();
        pk[0] = 8'h50; pk[1] = 8'h82;
        send_packet(8'h01, 2, 8'h2B, 1'b1);
        send_packet(8'h00, 0, 8'h00, 1'b1);

        // Reset just after the first data byte of a LEN=3 packet.
        do_reset();
        w0 = wr_seen;
        send_byte(8'h40, 1'b0, 8'h00, 1'b0);
        send_byte(8'h03, 1'b0, 8'h00, 1'b0);
        send_byte(8'hA1, 1'b1, 8'h40, 1'b0);
        do_reset();
        repeat (2) @(negedge clk);
        check("mid_reset_one_write", wr_seen - w0, 1);
        pk[0] = 8'h33;
        send_packet(8'h10, 1, good_chk(8'h10, 1), 1'b0);
        send_packet(8'h00, 0, 8'h00, 1'b0);

        // Terminator-only stream.
        do_reset();
        w0 = wr_seen;
        send_packet(8'h00, 0, 8'h00, 1'b0);
        check("term_only_no_write", wr_seen - w0, 0);
        ignore_bytes(2, 1'b1, 1'b0);

        // Random sessions: good packets then either a terminator or a corrupted packet.
        for (int s = 0; s < 8; s++) begin
            do_reset();
            thr = 1'($urandom);
            npk = int'($urandom_range(1, 4));
            for (int p = 0; p < npk; p++) begin
                addr = (p == 0 && s == 2) ? 8'hFD : 8'($urandom);
                len  = int'($urandom_range(1, 6));
                for (int i = 0; i < len; i++) pk[i] = 8'($urandom);
                send_packet(addr, len, good_chk(addr, len), thr);
            end
            addr = 8'($urandom);
            if (s % 2 == 1) begin
                len = int'($urandom_range(1, 6));
                for (int i = 0; i < len; i++) pk[i] = 8'($urandom);
                send_packet(addr, len, good_chk(addr, len) + 8'($urandom_range(1, 255)), thr);
                ignore_bytes(2, 1'b0, 1'b1);
            end else begin
                send_packet(addr, 0, good_chk(addr, 0), thr);
                ignore_bytes(2, 1'b1, 1'b0);
            end
        end

        for (int i = 0; i < 256; i++) begin
            check($sformatf("mem[%0h]", i), dut_mem[i], model_mem[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
